// File: rtl/pipe_sel_buf.sv
// N:1 datapath select feeding a registered two-entry skid buffer with a
// valid/ready handshake, synchronous flush and a sticky out-of-range select flag.
module pipe_sel_buf #(
  parameter int              WL      = 32,
  parameter int              NIN     = 4,
  parameter int              SW      = $clog2(NIN),
  parameter logic [WL-1:0]   RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NIN*WL-1:0] din,
  input  logic [SW-1:0]     sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [WL-1:0]     dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t          state_reg, state_next;
  logic [WL-1:0]   main_reg, main_next;
  logic [WL-1:0]   skid_reg, skid_next;
  logic            in_ready_reg, in_ready_next;
  logic            out_valid_reg, out_valid_next;
  logic            sel_err_reg, sel_err_next;

  logic [WL-1:0]   chan [NIN];
  logic [WL-1:0]   word;
  logic            sel_ok;
  logic            accept;
  logic            pop;

  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : g_chan
      assign chan[gi] = din[gi*WL +: WL];
    end
  endgenerate

  // Out-of-range selects fall back to channel 0 and are reported via sel_ok.
  always_comb begin
    word   = chan[0];
    sel_ok = 1'b0;
    for (int k = 0; k < NIN; k++) begin
      if (sel == SW'(k)) begin
        word   = chan[k];
        sel_ok = 1'b1;
      end
    end
  end

  assign accept = in_valid & in_ready_reg;
  assign pop    = out_valid_reg & out_ready;

  always_comb begin
    state_next   = state_reg;
    main_next    = main_reg;
    skid_next    = skid_reg;
    sel_err_next = sel_err_reg | (accept & ~sel_ok);

    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          main_next  = word;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_next = FULL;
          skid_next  = word;
        end else if (accept && pop) begin
          main_next = word;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next = ONE;
          main_next  = skid_reg;
        end
      end
      default: state_next = EMPTY;
    endcase

    // Flush wins over everything; the select error is deliberately kept.
    if (flush) begin
      state_next = EMPTY;
      main_next  = RST_VAL;
    end

    in_ready_next  = (state_next != FULL);
    out_valid_next = (state_next != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      main_reg      <= RST_VAL;
      skid_reg      <= RST_VAL;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      sel_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      sel_err_reg   <= sel_err_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign dout      = main_reg;
  assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_pipe_sel_buf.sv
// Scoreboard bench for pipe_sel_buf: a 4-input and a 3-input instance driven
// by directed vectors, with per-instance monitors popping expected words.
module tb_pipe_sel_buf;
  localparam int            WL  = 32;
  localparam logic [WL-1:0] RV4 = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [4*WL-1:0] din4;
  logic [1:0]      sel4;
  logic            iv4, ir4, fl4, ov4, or4, se4;
  logic [WL-1:0]   dout4;

  logic [3*WL-1:0] din3;
  logic [1:0]      sel3;
  logic            iv3, ir3, fl3, ov3, or3, se3;
  logic [WL-1:0]   dout3;

  int tests = 0;
  int fails = 0;
  logic [WL-1:0] q4[$];
  logic [WL-1:0] q3[$];

  pipe_sel_buf #(.WL(WL), .NIN(4), .RST_VAL(RV4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4), .in_valid(iv4),
    .in_ready(ir4), .flush(fl4), .dout(dout4), .out_valid(ov4),
    .out_ready(or4), .sel_err(se4)
  );

  pipe_sel_buf #(.WL(WL), .NIN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .in_valid(iv3),
    .in_ready(ir3), .flush(fl3), .dout(dout3), .out_valid(ov3),
    .out_ready(or3), .sel_err(se3)
  );

  task automatic check(input string name, input logic [WL-1:0] act,
                       input logic [WL-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s: %0h", name, act);
    end
  endtask

  // Monitors: every completed output transfer must match the queue head.
  always @(negedge clk) begin
    if (ov4 && or4) begin
      if (q4.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon4: got word %0h, expected no output", dout4);
      end else begin
        check("mon4", dout4, q4.pop_front());
      end
    end
    if (fl4) q4.delete();
  end

  always @(negedge clk) begin
    if (ov3 && or3) begin
      if (q3.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon3: got word %0h, expected no output", dout3);
      end else begin
        check("mon3", dout3, q3.pop_front());
      end
    end
    if (fl3) q3.delete();
  end

  task automatic push4(input logic [1:0] s, input logic [WL-1:0] exp);
    iv4  = 1'b1;
    sel4 = s;
    @(negedge clk);
    if (ir4 && !fl4) q4.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic push3(input logic [1:0] s, input logic [WL-1:0] exp);
    iv3  = 1'b1;
    sel3 = s;
    @(negedge clk);
    if (ir3 && !fl3) q3.push_back(exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    din4 = {32'd4, 32'd3, 32'd2, 32'd1};
    din3 = {32'd30, 32'd20, 32'd10};
    sel4 = '0; iv4 = 0; fl4 = 0; or4 = 0;
    sel3 = '0; iv3 = 0; fl3 = 0; or3 = 0;

    // Power-on reset
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ov", 32'(ov4), 0);
    check("rst_ready", 32'(ir4), 1);
    check("rst_dout", dout4, RV4);
    check("rst_selerr", 32'(se4), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming, one word per cycle
    or4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv4  = 1'b1;
      sel4 = i[1:0];
      @(negedge clk);
      check("stream_ready", 32'(ir4), 1);
      if (ir4) q4.push_back(32'(i + 1));
      @(posedge clk); #1;
    end
    iv4 = 1'b0;
    @(negedge clk);
    check("stream_last_ov", 32'(ov4), 1);
    check("stream_last", dout4, 4);
    @(negedge clk);
    check("stream_drain", 32'(ov4), 0);
    @(posedge clk); #1;

    // Backpressure fills the skid register
    or4 = 1'b0;
    push4(2'd1, 32'd2);
    push4(2'd2, 32'd3);
    iv4 = 1'b0;
    @(negedge clk);
    check("bp_ready_low", 32'(ir4), 0);
    check("bp_ov", 32'(ov4), 1);
    check("bp_dout", dout4, 2);
    repeat (2) begin
      @(negedge clk);
      check("bp_hold", dout4, 2);
    end
    @(posedge clk); #1 or4 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_ready_back", 32'(ir4), 1);
    @(posedge clk); #1;

    // Accept and pop together in ONE
    push4(2'd0, 32'd1);
    push4(2'd3, 32'd4);
    iv4 = 1'b0;
    @(negedge clk);
    check("ap_ready", 32'(ir4), 1);
    check("ap_ov", 32'(ov4), 1);
    check("ap_dout", dout4, 4);
    @(posedge clk); #1;

    // Flush while FULL with a word on offer
    or4 = 1'b0;
    push4(2'd1, 32'd2);
    push4(2'd2, 32'd3);
    iv4 = 1'b1; sel4 = 2'd3; fl4 = 1'b1;
    @(posedge clk); #1;
    fl4 = 1'b0; iv4 = 1'b0;
    @(negedge clk);
    check("fl_ov", 32'(ov4), 0);
    check("fl_dout", dout4, RV4);
    check("fl_ready", 32'(ir4), 1);
    @(posedge clk); #1;
    or4 = 1'b1;
    push4(2'd0, 32'd1);
    iv4 = 1'b0;
    @(negedge clk);
    check("fl_after", dout4, 1);
    @(posedge clk); #1;

    // Asynchronous reset while FULL
    or4 = 1'b0;
    push4(2'd1, 32'd2);
    push4(2'd2, 32'd3);
    iv4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ov", 32'(ov4), 0);
    check("mrst_ready", 32'(ir4), 1);
    check("mrst_dout", dout4, RV4);
    check("mrst_selerr", 32'(se4), 0);
    q4.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mrst_stay_empty", 32'(ov4), 0);
    @(posedge clk); #1;

    // Out-of-range select on the 3-input instance
    or3 = 1'b1;
    push3(2'd2, 32'd30);
    iv3 = 1'b0;
    @(negedge clk);
    check("se_clean", 32'(se3), 0);
    @(posedge clk); #1;
    push3(2'd3, 32'd10);
    iv3 = 1'b0;
    @(negedge clk);
    check("se_set", 32'(se3), 1);
    check("se_dout_ch0", dout3, 10);
    @(posedge clk); #1 fl3 = 1'b1;
    @(posedge clk); #1 fl3 = 1'b0;
    @(negedge clk);
    check("se_after_flush", 32'(se3), 1);
    check("se_flush_ov", 32'(ov3), 0);
    #1 rst_n = 1'b0;
    #1;
    check("se_after_rst", 32'(se3), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("q4_empty", 32'(q4.size()), 0);
    check("q3_empty", 32'(q3.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
